elastic_pipe_reg: RTL
=====================

Name: elastic_pipe_reg

Overview:
- Parametrised successor to the single-stage N-bit register: a chain of DEPTH WIDTH-bit register stages with a per-stage valid bit and valid/ready flow control.
- Empty stages are collapsed (bubble squeeze), so a stall downstream does not block upstream stages that have free slots.
- Adds synchronous flush and an occupancy count.
- Used between tile fetch, tile decode and pixel write stages of the drawing pipeline, wherever latency must be inserted without losing data under backpressure.

Parameters:
- WIDTH, 8, data bits per stage; 1 or more.
- DEPTH, 3, number of register stages; 1 or more.
- CNTW, clog2(DEPTH+1), width of the occupancy count; derived, not overridden.

Ports:
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous active-low reset.
- Enable  in  1  global advance; 0 freezes all state.
- Flush  in  1  synchronous clear of all valid bits.
- in_data  in  WIDTH  upstream data.
- in_valid  in  1  upstream data valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  WIDTH  data of the last stage (stage DEPTH-1).
- out_valid  out  1  last stage holds valid data.
- out_ready  in  1  downstream accepts this cycle.
- occupancy  out  CNTW  number of valid stages, 0..DEPTH.

Behaviour:
- Reset (Resetn=0, asynchronous): all valid bits 0, all data registers 0, out_valid=0, out_data=0, occupancy=0, in_ready=0 while in reset. Reset asserted mid-transfer drops all contents; no partial state survives.
- Stage i holds v[i] and d[i]; stage 0 is nearest the input.
- Per-stage ready:
  - r[DEPTH-1] = ~v[DEPTH-1] | out_ready.
  - r[i] = ~v[i] | r[i+1].
  - This is a combinational chain, with no registered skid.
- in_ready = Enable & ~Flush & r[0].
- in fire = in_valid & in_ready.
- out fire = out_valid & out_ready & Enable & ~Flush.
- On a clock edge with Enable=1 and Flush=0, for each stage i where r[i]=1:
  - Stage 0 loads {in fire, in_data}.
  - Stage i>0 loads {v[i-1], d[i-1]}.
  - Stages with r[i]=0 hold.
  - d[i] is written only when the incoming valid is 1; an empty stage keeps its stale data.
- Minimum latency: an accepted word appears at out_valid DEPTH cycles after the in-fire edge, given no stall.
- Throughput: 1 word per cycle while out_ready=1.
- Full: all v=1 and out_ready=0 gives in_ready=0. Full with out_ready=1 gives in_ready=1; simultaneous in and out transfer keeps occupancy at DEPTH.
- Empty: occupancy=0, out_valid=0. out_data still shows stale d[DEPTH-1], so consumers qualify it with out_valid.
- Enable=0: no register changes; in_ready=0; out_valid/out_data unchanged and still driven; no out fire. out_ready is ignored.
- Flush=1 with Enable=1: all v cleared at the edge; input on that cycle is refused (in_ready=0); no out fire that cycle; data registers unchanged.
- Flush=1 with Enable=0: no effect, because Enable gates all state.
- occupancy is registered: popcount of the v bits after the edge. It changes by at most +1, 0 or -1 per cycle, except on flush, where it drops to 0.

Decomposition:
- Shared header/package: clog2 function used for CNTW, and default WIDTH/DEPTH constants for the draw pipeline.
- One natural sub-module: pipe_stage.
  - Contents: one v/d register pair with its load condition.
  - Inputs: Clock, Resetn, load, valid_in, data_in; outputs v, d.
  - Instantiated DEPTH times in a generate loop.
  - The ready chain and occupancy counter live in the top level.

Test Plan (WIDTH=8, DEPTH=3):
- Reset then stream: drive in_valid=1 with data 0x11, 0x22, 0x33, 0x44 on consecutive cycles, out_ready=1 → out_valid first high 3 cycles after 0x11 is accepted; outputs 0x11..0x44 on consecutive cycles; occupancy steady at 3 during the stream.
- Backpressure fill: out_ready=0, push 0xA1, 0xA2, 0xA3 → in_ready falls after the 3rd accept, occupancy=3, out_data=0xA1. Raising out_ready for 1 cycle pops 0xA1, and a new 0xA4 is accepted in the same cycle.
- Bubble squeeze: push 0x05, idle 2 cycles, push 0x06, with out_ready=0 → 0x05 reaches stage 2 and 0x06 advances to stage 1 (occupancy=2), leaving no gap.
- Flush: occupancy=3, assert Flush for 1 cycle with in_valid=1, in_data=0x77 → next cycle occupancy=0, out_valid=0, and 0x77 is never output.
- Enable freeze: mid-stream, hold Enable=0 for 4 cycles with out_ready=1 → no output change, in_ready=0, occupancy constant. The stream resumes in order afterwards, with no loss or duplication.
- Async reset: pulse Resetn low between clock edges with occupancy=2 → outputs go to 0 immediately, with no clock edge needed; after release, the first push 0x99 appears 3 cycles later.

Source files
------------

// File: rtl/elastic_pipe_reg_pkg.sv
// rtl/elastic_pipe_reg_pkg.sv - shared constants and helpers for the elastic pipeline register
package elastic_pipe_reg_pkg;

  localparam int DRAW_PIPE_WIDTH = 8;
  localparam int DRAW_PIPE_DEPTH = 3;

  // Ceiling log2; n must be 2 or more for a non-zero result.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/elastic_pipe_reg_pipe_stage.sv
// rtl/elastic_pipe_reg_pipe_stage.sv - one valid/data register pair of the elastic pipeline
module pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             v_o,
  output logic [WIDTH-1:0] d_o
);

  logic             v_q;
  logic [WIDTH-1:0] d_q;

  // Data is only captured alongside a valid word, so empty stages keep stale data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else if (load_i) begin
      v_q <= valid_i;
      if (valid_i) begin
        d_q <= data_i;
      end
    end
  end

  assign v_o = v_q;
  assign d_o = d_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// rtl/elastic_pipe_reg.sv - DEPTH-stage valid/ready register chain with bubble squeeze, flush and occupancy
module elastic_pipe_reg
  import elastic_pipe_reg_pkg::*;
#(
  parameter  int WIDTH = DRAW_PIPE_WIDTH,
  parameter  int DEPTH = DRAW_PIPE_DEPTH,
  localparam int CNTW  = clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CNTW-1:0]  occupancy_o
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] r;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] vin;
  logic [DEPTH-1:0] v_next;
  logic [WIDTH-1:0] d   [DEPTH];
  logic [WIDTH-1:0] din [DEPTH];
  logic             adv;
  logic             in_fire;
  logic [CNTW-1:0]  occ_q;
  logic [CNTW-1:0]  occ_d;

  assign adv = en_i & ~flush_i;

  // A stage can accept when it is empty or the stage after it can move on.
  always_comb begin
    r = '0;
    r[DEPTH-1] = ~v[DEPTH-1] | out_ready_i;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      r[i] = ~v[i] | r[i+1];
    end
  end

  assign in_ready_o = rst_ni & adv & r[0];
  assign in_fire    = in_valid_i & in_ready_o;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign vin[i] = in_fire;
      assign din[i] = in_data_i;
    end else begin : g_body
      assign vin[i] = v[i-1] & ~flush_i;
      assign din[i] = d[i-1];
    end

    // Flush is a load of an empty word into every stage.
    assign load[i]   = en_i & (flush_i | r[i]);
    assign v_next[i] = load[i] ? vin[i] : v[i];

    pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (load[i]),
      .valid_i (vin[i]),
      .data_i  (din[i]),
      .v_o     (v[i]),
      .d_o     (d[i])
    );
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + CNTW'(v_next[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign out_valid_o = v[DEPTH-1];
  assign out_data_o  = d[DEPTH-1];
  assign occupancy_o = occ_q;

endmodule
